// File: rtl/fc_layer_seq_if.sv
// Bus between the fully-connected layer engine, its controller and its weight memory.
interface fc_layer_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_N       = 120,
    parameter int OUT_N      = 10
);
    localparam int AW = $clog2(IN_N * OUT_N);

    logic                        start;
    logic [DATA_WIDTH*IN_N-1:0]  fcInput;
    logic [DATA_WIDTH*OUT_N-1:0] fcBias;
    logic [AW-1:0]               wAddr;
    logic [DATA_WIDTH-1:0]       wData;
    logic [DATA_WIDTH*OUT_N-1:0] fcOutput;
    logic                        busy;
    logic                        done;
    logic                        outValid;

    modport master (output start, fcInput, fcBias, wData,
                    input  wAddr, fcOutput, busy, done, outValid);
    modport slave  (input  start, fcInput, fcBias, wData,
                    output wAddr, fcOutput, busy, done, outValid);
endinterface

// File: rtl/fc_layer_seq.sv
// Sequential single-precision fully-connected layer: one multiply-accumulate per cycle,
// weights streamed from an external 1-cycle-latency memory, optional ReLU on each output.
module fc_layer_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_N       = 120,
    parameter int OUT_N      = 10,
    parameter int ACT_MODE   = 0
) (
    input logic           clk,
    input logic           reset,
    fc_layer_seq_if.slave bus
);
    localparam int AW = $clog2(IN_N * OUT_N);
    localparam int IW = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int JW = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(IN_N - 1);
    localparam logic [JW-1:0] J_LAST = JW'(OUT_N - 1);

    typedef enum logic [2:0] {IDLE, PREFETCH, MAC, WRITE, DONE} stateT;

    stateT                       state, nextState;
    logic [DATA_WIDTH*IN_N-1:0]  xReg;
    logic [DATA_WIDTH*OUT_N-1:0] biasReg;
    logic [DATA_WIDTH*OUT_N-1:0] outReg;
    logic [DATA_WIDTH-1:0]       acc;
    logic [IW-1:0]               iCnt;
    logic [JW-1:0]               jCnt;
    logic [AW-1:0]               wAddrReg;
    logic                        outValidReg;

    // Denormals are flushed to zero; results are rounded to nearest-even.
    function automatic logic [31:0] floatMult(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] prod;
        logic [22:0] m;
        logic        g, st;
        logic [23:0] mr;
        int          e;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'hff && |a[22:0]) || (b[30:23] == 8'hff && |b[22:0]))
            return 32'h7fc00000;
        if (a[30:23] == 8'hff || b[30:23] == 8'hff)
            return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? 32'h7fc00000 : {s, 8'hff, 23'd0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
            return {s, 31'd0};
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            m  = prod[46:24];
            g  = prod[23];
            st = |prod[22:0];
            e  = e + 1;
        end else begin
            m  = prod[45:23];
            g  = prod[22];
            st = |prod[21:0];
        end
        mr = {1'b0, m} + 24'(g && (st || m[0]));
        if (mr[23]) e = e + 1;
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] floatAdd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big, sml;
        logic [50:0] mb, ms, sum, n;
        logic        g, st;
        logic [23:0] mr;
        int          d, p, e;
        if ((a[30:23] == 8'hff && |a[22:0]) || (b[30:23] == 8'hff && |b[22:0]))
            return 32'h7fc00000;
        if (a[30:23] == 8'hff && b[30:23] == 8'hff)
            return (a[31] != b[31]) ? 32'h7fc00000 : a;
        if (a[30:23] == 8'hff) return a;
        if (b[30:23] == 8'hff) return b;
        if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'd0} : b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        // Hidden bit sits at position 49; the 26 bits below the mantissa keep alignment exact
        // and anything shifted further out collapses into a sticky LSB.
        d  = int'(big[30:23]) - int'(sml[30:23]);
        mb = {2'b01, big[22:0], 26'd0};
        ms = {2'b01, sml[22:0], 26'd0};
        if (d > 49)
            ms = 51'd1;
        else if (d > 0)
            ms = (ms >> d) | 51'((ms & ((51'd1 << d) - 51'd1)) != 51'd0);
        sum = (big[31] == sml[31]) ? mb + ms : mb - ms;
        if (sum == 51'd0) return 32'd0;
        p = 0;
        for (int k = 0; k < 51; k++)
            if (sum[k]) p = k;
        e = int'(big[30:23]) + p - 49;
        if (p == 50)
            n = (sum >> 1) | {50'd0, sum[0]};
        else
            n = sum << (49 - p);
        g  = n[25];
        st = |n[24:0];
        mr = {1'b0, n[48:26]} + 24'(g && (st || n[26]));
        if (mr[23]) e = e + 1;
        if (e >= 255) return {big[31], 8'hff, 23'd0};
        if (e <= 0) return {big[31], 31'd0};
        return {big[31], e[7:0], mr[22:0]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] activate(input logic [DATA_WIDTH-1:0] v);
        if (ACT_MODE == 1 && v[DATA_WIDTH-1]) return '0;
        return v;
    endfunction

    always_comb begin
        nextState = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE:     if (bus.start) nextState = PREFETCH;
            PREFETCH: begin
                bus.busy  = 1'b1;
                nextState = MAC;
            end
            MAC: begin
                bus.busy = 1'b1;
                if (iCnt == I_LAST) nextState = WRITE;
            end
            WRITE: begin
                bus.busy  = 1'b1;
                nextState = (jCnt == J_LAST) ? DONE : PREFETCH;
            end
            DONE: begin
                bus.done  = 1'b1;
                nextState = IDLE;
            end
            default:  nextState = IDLE;
        endcase
    end

    // wAddr always runs one weight ahead of the MAC so wData lines up with x[iCnt].
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            xReg        <= '0;
            biasReg     <= '0;
            outReg      <= '0;
            acc         <= '0;
            iCnt        <= '0;
            jCnt        <= '0;
            wAddrReg    <= '0;
            outValidReg <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        xReg        <= bus.fcInput;
                        biasReg     <= bus.fcBias;
                        outValidReg <= 1'b0;
                        jCnt        <= '0;
                        wAddrReg    <= '0;
                    end
                end
                PREFETCH: begin
                    acc  <= biasReg[int'(jCnt)*DATA_WIDTH +: DATA_WIDTH];
                    iCnt <= '0;
                    if (IN_N > 1) wAddrReg <= wAddrReg + AW'(1);
                end
                MAC: begin
                    acc <= floatAdd(acc, floatMult(xReg[int'(iCnt)*DATA_WIDTH +: DATA_WIDTH], bus.wData));
                    if (iCnt != I_LAST) iCnt <= iCnt + IW'(1);
                    if (int'(iCnt) < IN_N - 2) wAddrReg <= wAddrReg + AW'(1);
                end
                WRITE: begin
                    outReg[int'(jCnt)*DATA_WIDTH +: DATA_WIDTH] <= activate(acc);
                    if (jCnt != J_LAST) begin
                        jCnt     <= jCnt + JW'(1);
                        wAddrReg <= wAddrReg + AW'(1);
                    end else begin
                        outValidReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wAddr    = wAddrReg;
    assign bus.fcOutput = outReg;
    assign bus.outValid = outValidReg;
endmodule

// File: doc/fc_layer_seq.md
FC_LAYER_SEQ -- requirements
Module: fc_layer_seq

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, IEEE-754 single-precision word width.
REQ-002 SHALL provide parameter IN_N, default 120, number of input activations.
REQ-003 SHALL provide parameter OUT_N, default 10, number of output neurons.
REQ-004 SHALL provide parameter ACT_MODE, default 0, output activation: 0 = identity, 1 = ReLU.
REQ-005 SHALL provide localparam AW = clog2(IN_N*OUT_N), weight address width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request a new layer evaluation.
REQ-009 fcInput  input  DATA_WIDTH*IN_N  input vector; element k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
REQ-010 fcBias  input  DATA_WIDTH*OUT_N  bias vector, same packing.
REQ-011 wAddr  output  AW  weight memory read address; weight(j,i) at address j*IN_N+i.
REQ-012 wData  input  DATA_WIDTH  weight memory read data, valid exactly one cycle after wAddr.
REQ-013 fcOutput  output  DATA_WIDTH*OUT_N  result vector, same packing.
REQ-014 busy  output  1  high while an evaluation is in progress.
REQ-015 done  output  1  one-cycle pulse on completion.
REQ-016 outValid  output  1  fcOutput holds a complete, current result.

Function
REQ-017 SHALL compute out[j] = act(bias[j] + sum over i of x[i]*w(j,i)), accumulating in ascending i, using the codebase's single-precision floatMult and floatAdd blocks.
REQ-018 SHALL implement states IDLE, PREFETCH, MAC, WRITE, DONE.
REQ-019 IDLE: start=1 captures fcInput and fcBias into internal registers, sets busy, clears outValid, sets j=0, and moves to PREFETCH; start=0 stays in IDLE.
REQ-020 PREFETCH (1 cycle): drives wAddr=j*IN_N, loads the accumulator with bias[j], sets i=0, and moves to MAC.
REQ-021 MAC (IN_N cycles): each cycle adds x[i]*wData to the accumulator, drives wAddr for i+1 (held at last address on final cycle), and moves to WRITE after i=IN_N-1.
REQ-022 WRITE (1 cycle): stores act(accumulator) into slot j of fcOutput, then goes to PREFETCH with j+1, or to DONE if j=OUT_N-1.
REQ-023 DONE (1 cycle): done=1, busy=0, outValid=1, next state IDLE.
REQ-024 Latency from the start-accepting edge to the done-high cycle SHALL be exactly OUT_N*(IN_N+2) cycles.
REQ-025 ReLU (ACT_MODE=1): sign bit 1 yields 32'h00000000, otherwise the value passes unchanged; identity mode passes the value unchanged, including -0 and NaN.
REQ-026 start SHALL be ignored outside IDLE, including in the DONE cycle.
REQ-027 Changes on fcInput/fcBias after capture SHALL NOT affect the running evaluation.
REQ-028 fcOutput slots SHALL update only in WRITE; completed slots remain valid until overwritten by the next evaluation.
REQ-029 Counters i and j SHALL never exceed IN_N-1 and OUT_N-1; wAddr SHALL never exceed IN_N*OUT_N-1.

Reset
REQ-030 reset=1 at any edge, including mid-evaluation, SHALL force IDLE, busy=0, done=0, outValid=0, fcOutput=0, wAddr=0, counters and accumulator to 0.
REQ-031 reset SHALL take priority over start in the same cycle.

Verification
REQ-032 IN_N=4, OUT_N=2, ACT_MODE=0; x=all 3f800000, w=all 3f800000, bias=0 -> done exactly 12 cycles after start edge; fcOutput = {40800000, 40800000}; outValid=1.
REQ-033 Same sizes; w(0,*)=bf800000, w(1,*)=3f800000, bias={3f800000, 0} -> ACT_MODE=0 gives out0=c0400000, out1=40800000; ACT_MODE=1 gives out0=00000000, out1=40800000.
REQ-034 Pulse start again at cycle 5 of a run and change fcInput to all 40000000 -> ignored; result and timing identical to REQ-032.
REQ-035 Assert reset at cycle 7 of a run -> next cycle busy=0, outValid=0, fcOutput=0; a following start completes correctly in 12 cycles.
REQ-036 Defaults (120x10) with a behavioural 1-cycle weight ROM and random operands -> done after 1220 cycles; each output within 1 ULP*IN_N of the sequential-order reference model; wAddr sequence 0..1199 with no gaps.
